// File: rtl/plru_pkg.sv
// Shared types and helpers for the per-set tree pseudo-LRU controller.
//   plru_op_t    : command encoding on req_op
//   plru_state_t : controller sequencing states
//   node_level() : depth of a tree node (root = level 0)
package plru_pkg;

   typedef enum logic [1:0] {
      TOUCH  = 2'd0,
      VICTIM = 2'd1,
      CLEAR  = 2'd2,
      RSVD   = 2'd3
   } plru_op_t;

   typedef enum logic [1:0] {
      IDLE,
      UPD,
      CLR,
      RSP
   } plru_state_t;

   // Nodes 2^l-1 .. 2^(l+1)-2 sit at level l.
   function automatic int node_level(input int n);
      int lvl;
      lvl = 0;
      for (int k = 1; k < 31; k++) begin
         if (n >= (1 << k) - 1) lvl = k;
      end
      return lvl;
   endfunction

endpackage

// File: rtl/plru_victim_find.sv
// Victim selection: walk from the root against each node bit (stored 0 ->
// go right, stored 1 -> go left); the taken directions, MSB first, form
// the victim way. Same node indexing as update_LRU.
//   bits   : tree bits of one set, bit n = node n
//   victim : selected way
module plru_victim_find #(
   parameter int unsigned A_SIZE = 8,
   localparam int unsigned W = $clog2(A_SIZE),
   localparam int unsigned B = A_SIZE - 1
) (
   input  logic [B-1:0] bits,
   output logic [W-1:0] victim
);

   always_comb begin
      int   node;
      int   v;
      logic nb;
      node = 0;
      v    = 0;
      nb   = 1'b0;
      for (int l = 0; l < int'(W); l++) begin
         nb = 1'b0;
         for (int n = 0; n < int'(B); n++) begin
            if (n == node) nb = bits[n];
         end
         v    = v * 2 + (nb ? 0 : 1);
         node = 2 * node + 1 + (nb ? 0 : 1);
      end
      victim = v[W-1:0];
   end

endmodule

// File: rtl/update_LRU.sv
// Tree PLRU path update: every node on the path to `way` takes the path
// direction bit (0 = left, 1 = right, MSB at the root); other nodes keep
// their value.
//   way     : accessed way
//   lru_in  : current tree bits, bit n = node n
//   lru_out : updated tree bits
module update_LRU
   import plru_pkg::*;
#(
   parameter int unsigned A_SIZE = 8,
   localparam int unsigned W = $clog2(A_SIZE),
   localparam int unsigned B = A_SIZE - 1
) (
   input  logic [W-1:0] way,
   input  logic [B-1:0] lru_in,
   output logic [B-1:0] lru_out
);

   always_comb begin
      lru_out = lru_in;
      for (int n = 0; n < int'(B); n++) begin
         // Node n is on the path when its position within its level equals
         // the top `level` bits of the way.
         if ((int'(way) >> (int'(W) - node_level(n))) == (n + 1 - (1 << node_level(n)))) begin
            lru_out[n] = ((int'(way) >> (int'(W) - 1 - node_level(n))) & 1) != 0;
         end
      end
   end

endmodule

// File: rtl/plru_set_ctrl.sv
// Per-set tree pseudo-LRU controller. Holds N_SETS x (A_SIZE-1) PLRU bits
// and serialises TOUCH / VICTIM / CLEAR commands, one in flight at a time.
//   clk, rst_n            : clock, async active-low reset
//   req_valid/req_ready   : command handshake
//   req_op/req_set/req_way: command, target set, accessed way (TOUCH)
//   rsp_valid/rsp_ready   : response handshake
//   rsp_way               : victim (VICTIM), echoed way (TOUCH), else 0
//   rsp_err               : reserved op was issued
module plru_set_ctrl
   import plru_pkg::*;
#(
   parameter int unsigned A_SIZE = 8,
   parameter int unsigned N_SETS = 16,
   localparam int unsigned W = $clog2(A_SIZE),
   localparam int unsigned S = $clog2(N_SETS),
   localparam int unsigned B = A_SIZE - 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [1:0]   req_op,
   input  logic [S-1:0] req_set,
   input  logic [W-1:0] req_way,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_way,
   output logic         rsp_err
);

   logic [B-1:0] lru_q [N_SETS];

   plru_state_t  state_q, state_d;
   plru_op_t     op_q, op_d;
   logic [S-1:0] set_q, set_d;
   logic [W-1:0] way_q, way_d;
   logic [S-1:0] cnt_q, cnt_d;
   logic [W-1:0] rsp_way_q, rsp_way_d;
   logic         rsp_err_q, rsp_err_d;

   logic         wr_en;
   logic [S-1:0] wr_set;
   logic [B-1:0] wr_bits;
   logic [B-1:0] cur_bits;
   logic [B-1:0] upd_bits;
   logic [W-1:0] victim_way;
   logic [W-1:0] upd_sel;

   assign cur_bits = lru_q[set_q];
   assign upd_sel  = (op_q == VICTIM) ? victim_way : way_q;

   plru_victim_find #(
      .A_SIZE (A_SIZE)
   ) u_victim (
      .bits   (cur_bits),
      .victim (victim_way)
   );

   update_LRU #(
      .A_SIZE (A_SIZE)
   ) u_update (
      .way     (upd_sel),
      .lru_in  (cur_bits),
      .lru_out (upd_bits)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      set_d     = set_q;
      way_d     = way_q;
      cnt_d     = cnt_q;
      rsp_way_d = rsp_way_q;
      rsp_err_d = rsp_err_q;
      wr_en     = 1'b0;
      wr_set    = set_q;
      wr_bits   = upd_bits;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               op_d    = plru_op_t'(req_op);
               set_d   = req_set;
               way_d   = req_way;
               state_d = (plru_op_t'(req_op) == CLEAR) ? CLR : UPD;
            end
         end
         UPD: begin
            unique case (op_q)
               TOUCH: begin
                  wr_en     = 1'b1;
                  rsp_way_d = way_q;
                  rsp_err_d = 1'b0;
               end
               VICTIM: begin
                  wr_en     = 1'b1;
                  rsp_way_d = victim_way;
                  rsp_err_d = 1'b0;
               end
               default: begin
                  // Only RSVD reaches here; CLEAR goes through CLR.
                  rsp_way_d = '0;
                  rsp_err_d = 1'b1;
               end
            endcase
            state_d = RSP;
         end
         CLR: begin
            wr_en   = 1'b1;
            wr_set  = cnt_q;
            wr_bits = '0;
            if (cnt_q == S'(N_SETS - 1)) begin
               cnt_d     = '0;
               rsp_way_d = '0;
               rsp_err_d = 1'b0;
               state_d   = RSP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RSP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         op_q      <= TOUCH;
         set_q     <= '0;
         way_q     <= '0;
         cnt_q     <= '0;
         rsp_way_q <= '0;
         rsp_err_q <= 1'b0;
         for (int i = 0; i < int'(N_SETS); i++) lru_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         set_q     <= set_d;
         way_q     <= way_d;
         cnt_q     <= cnt_d;
         rsp_way_q <= rsp_way_d;
         rsp_err_q <= rsp_err_d;
         if (wr_en) lru_q[wr_set] <= wr_bits;
      end
   end

   assign rsp_way = rsp_way_q;
   assign rsp_err = rsp_err_q;

endmodule
